// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline-stage types and constants
// Purpose: state encoding for elastic pipe stages, the bubble control word,
// and ALU op codes referenced by control payloads.
// Ports: none (package).
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;

  // Bubble control: ALU add, alu_src=1 (bit 6), every side-effect flag clear.
  localparam logic [15:0] RV_NOP_CTRL = 16'h0040;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
// Purpose: counts cycles with inc=1, sticking at all-ones.
// Ports: clk, rst (async, active-high), inc (count this cycle),
//        clear (synchronous zero), count (current value).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - two-entry elastic (skid) pipeline stage
// Purpose: decouples upstream/downstream handshakes with a main slot that
// drives the outputs and a skid slot that absorbs one entry when the
// registered in_ready lags a downstream stall.
// Ports: clk, rst (async, active-high), flush (sync kill),
//        in_valid/in_ready/in_data/in_ctrl (upstream),
//        out_valid/out_ready/out_data/out_ctrl (downstream),
//        stall_cnt (saturating count of out_valid & !out_ready cycles).
module pipe_stage_elastic
  import rv_pipe_pkg::*;
#(
  parameter int                DATA_W   = 96,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(RV_NOP_CTRL),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_t      st_q, st_d;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic              in_ready_q;
  logic              accept, emit;
  logic              load_main_in, load_main_skid, load_skid;

  assign in_ready  = in_ready_q;
  assign out_valid = (st_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;
  assign out_data  = main_data_q;
  // Payload slots are not cleared on drain, so control is masked instead.
  assign out_ctrl  = out_valid ? main_ctrl_q : NOP_CTRL;

  always_comb begin
    st_d           = st_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (st_q)
      ST_EMPTY: begin
        if (accept) begin
          st_d         = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          st_d      = ST_TWO;
          load_skid = 1'b1;
        end else if (emit) begin
          st_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (emit) begin
          st_d           = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: st_d = ST_EMPTY;
    endcase
    // Flush wins over every handshake, including a same-cycle accept.
    if (flush) begin
      st_d           = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      st_q       <= st_d;
      in_ready_q <= (st_d != ST_TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_q <= '0;
      main_ctrl_q <= NOP_CTRL;
      skid_data_q <= '0;
      skid_ctrl_q <= NOP_CTRL;
    end else begin
      if (load_main_in) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .clear(1'b0),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

  localparam int DW = 96;
  localparam int CW = 16;
  localparam int KW = 4;
  localparam logic [CW-1:0] NOP = 16'h0040;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [KW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: FIFO of at most two entries, ready flag, saturating stall count.
  logic [DW-1:0] m_data[$];
  logic [CW-1:0] m_ctrl[$];
  bit            m_rdy = 1'b1;
  int            m_stall = 0;

  pipe_stage_elastic #(
    .DATA_W  (DW),
    .CTRL_W  (CW),
    .NOP_CTRL(NOP),
    .CNT_W   (KW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data.delete();
    m_ctrl.delete();
    m_rdy   = 1'b1;
    m_stall = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_valid"}, 128'(out_valid), 128'(m_data.size() > 0));
    check({tag, ".in_ready"}, 128'(in_ready), 128'(m_rdy));
    check({tag, ".out_ctrl"}, 128'(out_ctrl), (m_ctrl.size() > 0) ? 128'(m_ctrl[0]) : 128'(NOP));
    if (m_data.size() > 0)
      check({tag, ".out_data"}, 128'(out_data), 128'(m_data[0]));
    if (m_data.size() == 2)
      check({tag, ".rdy_in_two"}, 128'(in_ready), 128'(0));
    check({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(m_stall));
  endtask

  // Drive one cycle from just after a falling edge, check, then advance the model.
  task automatic cycle(input string tag, input bit iv, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input bit ordy, input bit fl);
    bit acc, emi;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    check_model(tag);
    @(posedge clk);
    acc = iv && m_rdy;
    emi = (m_data.size() > 0) && ordy;
    if ((m_data.size() > 0) && !ordy)
      m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
    if (fl) begin
      m_data.delete();
      m_ctrl.delete();
      m_rdy = 1'b1;
    end else begin
      if (emi) begin
        void'(m_data.pop_front());
        void'(m_ctrl.pop_front());
      end
      if (acc) begin
        m_data.push_back(d);
        m_ctrl.push_back(c);
      end
      m_rdy = (m_data.size() < 2);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [CW-1:0] rc;

    model_reset();
    repeat (2) @(negedge clk);
    check("rst.out_valid", 128'(out_valid), 128'(0));
    check("rst.in_ready", 128'(in_ready), 128'(1));
    check("rst.out_ctrl", 128'(out_ctrl), 128'(16'h0040));
    check("rst.out_data", 128'(out_data), 128'(0));
    check("rst.stall_cnt", 128'(stall_cnt), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Streaming 1,2,3 with downstream always ready.
    cycle("stream1", 1'b1, 96'd1, 16'h0011, 1'b1, 1'b0);
    check("stream.d1", 128'(out_data), 128'(1));
    check("stream.rdy1", 128'(in_ready), 128'(1));
    cycle("stream2", 1'b1, 96'd2, 16'h0012, 1'b1, 1'b0);
    check("stream.d2", 128'(out_data), 128'(2));
    cycle("stream3", 1'b1, 96'd3, 16'h0013, 1'b1, 1'b0);
    check("stream.d3", 128'(out_data), 128'(3));
    check("stream.rdy3", 128'(in_ready), 128'(1));
    cycle("stream_drain", 1'b0, '0, '0, 1'b1, 1'b0);
    check("stream.empty", 128'(out_valid), 128'(0));
    check("stream.stall", 128'(stall_cnt), 128'(0));

    // Backpressure: A, B fill both slots.
    cycle("bp_a", 1'b1, 96'hA, 16'h00A0, 1'b0, 1'b0);
    cycle("bp_b", 1'b1, 96'hB, 16'h00B0, 1'b0, 1'b0);
    check("bp.rdy_full", 128'(in_ready), 128'(0));
    check("bp.hold_a", 128'(out_data), 128'(96'hA));
    cycle("bp_hold", 1'b1, 96'hEE, 16'h00EE, 1'b0, 1'b0);
    check("bp.still_a", 128'(out_data), 128'(96'hA));
    check("bp.ctrl_a", 128'(out_ctrl), 128'(16'h00A0));
    cycle("bp_pop_a", 1'b0, '0, '0, 1'b1, 1'b0);
    check("bp.b_head", 128'(out_data), 128'(96'hB));
    check("bp.rdy_back", 128'(in_ready), 128'(1));
    cycle("bp_pop_b", 1'b0, '0, '0, 1'b1, 1'b0);
    check("bp.empty", 128'(out_valid), 128'(0));
    check("bp.stall", 128'(stall_cnt), 128'(2));

    // Flush while full, C on the input.
    cycle("fl_a", 1'b1, 96'h1A, 16'h01A0, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, 96'h1B, 16'h01B0, 1'b0, 1'b0);
    cycle("fl_c", 1'b1, 96'h1C, 16'h01C0, 1'b0, 1'b1);
    check("fl.out_valid", 128'(out_valid), 128'(0));
    check("fl.out_ctrl", 128'(out_ctrl), 128'(NOP));
    check("fl.in_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 3; i++) begin
      cycle("fl_drain", 1'b0, '0, '0, 1'b1, 1'b0);
      check("fl.no_c", 128'(out_valid), 128'(0));
    end
    // Flush in ONE drops a same-cycle accept.
    cycle("fl1_d", 1'b1, 96'h1D, 16'h01D0, 1'b0, 1'b0);
    cycle("fl1_e", 1'b1, 96'h1E, 16'h01E0, 1'b1, 1'b1);
    check("fl1.dropped", 128'(out_valid), 128'(0));
    check("fl1.stall_kept", 128'(stall_cnt), 128'(4));

    // Saturation of the 4-bit stall counter.
    cycle("sat_load", 1'b1, 96'h5A, 16'h05A0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("sat", 1'b0, '0, '0, 1'b0, 1'b0);
    check("sat.at15", 128'(stall_cnt), 128'(15));
    cycle("sat_hold", 1'b0, '0, '0, 1'b0, 1'b0);
    check("sat.hold15", 128'(stall_cnt), 128'(15));
    cycle("sat_drain", 1'b0, '0, '0, 1'b1, 1'b0);

    // Async reset between edges while in ONE.
    cycle("ar_load", 1'b1, 96'h77, 16'h0770, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("ar.out_valid", 128'(out_valid), 128'(0));
    check("ar.in_ready", 128'(in_ready), 128'(1));
    check("ar.out_ctrl", 128'(out_ctrl), 128'(NOP));
    check("ar.out_data", 128'(out_data), 128'(0));
    check("ar.stall_cnt", 128'(stall_cnt), 128'(0));
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle("ar_idle", 1'b0, '0, '0, 1'b1, 1'b0);
    check("ar.no_emit", 128'(out_valid), 128'(0));
    cycle("ar_new", 1'b1, 96'h88, 16'h0880, 1'b1, 1'b0);
    check("ar.new_valid", 128'(out_valid), 128'(1));
    check("ar.new_data", 128'(out_data), 128'(96'h88));

    // Random traffic against the reference queue.
    for (int i = 0; i < 10000; i++) begin
      rd = {$urandom, $urandom, $urandom};
      rc = 16'($urandom);
      cycle("rnd", ($urandom_range(0, 9) < 6), rd, rc,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 4; i++) cycle("rnd_drain", 1'b0, '0, '0, 1'b1, 1'b0);
    check("end.empty", 128'(out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 SHALL have parameter DATA_W, 96, datapath payload width (pc, operands, immediate).
REQ-002 SHALL have parameter CTRL_W, 16, control payload width (alu_op, mem/reg/branch/jump/size/sign flags).
REQ-003 SHALL have parameter NOP_CTRL, 16'h0040, control value presented while the stage holds a bubble (ALU add, alu_src=1, all side-effect flags 0).
REQ-004 SHALL have parameter CNT_W, 16, width of the stall-cycle counter.
REQ-005 SHALL have port clk input 1 clock; all state updates on the rising edge.
REQ-006 SHALL have port rst input 1 reset, asynchronous, active-high.
REQ-007 SHALL have port flush input 1 synchronous kill of all held entries.
REQ-008 SHALL have port in_valid input 1 upstream entry valid.
REQ-009 SHALL have port in_ready output 1 stage can accept; driven from a register only.
REQ-010 SHALL have port in_data input DATA_W upstream payload.
REQ-011 SHALL have port in_ctrl input CTRL_W upstream control.
REQ-012 SHALL have port out_valid output 1 downstream entry valid.
REQ-013 SHALL have port out_ready input 1 downstream accepts.
REQ-014 SHALL have port out_data output DATA_W head payload.
REQ-015 SHALL have port out_ctrl output CTRL_W head control; NOP_CTRL when out_valid=0.
REQ-016 SHALL have port stall_cnt output CNT_W saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL hold two entries: main slot (drives outputs) and skid slot.
REQ-018 SHALL implement states EMPTY (no entries), ONE (main only), TWO (main+skid).
REQ-019 SHALL define handshakes: accept = in_valid & in_ready; emit = out_valid & out_ready.
REQ-020 SHALL transition EMPTY->ONE on accept, loading main with no bubble cycle (latency 1 cycle input to output).
REQ-021 SHALL in ONE: accept&emit -> ONE with main reloaded; accept&!emit -> TWO, input into skid; !accept&emit -> EMPTY; else hold.
REQ-022 SHALL in TWO: emit -> ONE with skid moved to main; else hold; in_ready=0 so no accept possible.
REQ-023 SHALL drive in_ready registered = (next state != TWO).
REQ-024 SHALL, on flush, go to EMPTY next cycle, discard any same-cycle accept, set in_ready=1; flush has priority over all handshakes.
REQ-025 SHALL keep out_data, out_ctrl stable while out_valid=1 and out_ready=0.
REQ-026 SHALL preserve entry order; no entry duplicated or dropped except by flush.
REQ-027 SHALL increment stall_cnt each stall cycle, saturating at all-ones; flush does not clear it.
REQ-028 SHALL not require payload registers to clear when slots become empty; only valid state and out_ctrl masking matter.

Reset
REQ-029 SHALL on rst: state EMPTY, out_valid=0, in_ready=1, out_ctrl=NOP_CTRL, out_data=0, skid payload=0, stall_cnt=0.
REQ-030 SHALL abandon any in-flight entry on rst mid-operation; first accept after deassertion appears at output one cycle later.

Structure
REQ-031 SHALL place state encoding (EMPTY/ONE/TWO) and the NOP control constant in shared package rv_pipe_pkg, alongside ALU op codes.
REQ-032 SHALL implement stall_cnt in one sub-module sat_counter (parameter width, inc, clear); everything else flat.

Verification
REQ-033 SHALL check streaming: in_valid=1, out_ready=1, data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each, in_ready stays 1, stall_cnt=0.
REQ-034 SHALL check backpressure: send A,B with out_ready=0 -> state TWO, in_ready=0 after B, out_data=A held; raise out_ready -> A then B emitted, in_ready=1 after A leaves.
REQ-035 SHALL check flush in TWO with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=NOP_CTRL, in_ready=1; C never emitted.
REQ-036 SHALL check CNT_W=4, 20 stall cycles -> stall_cnt=15 and holds.
REQ-037 SHALL check async rst asserted between clock edges in state ONE -> outputs reach reset values immediately, no emit after deassertion without new accept.
REQ-038 SHALL check random in_valid/out_ready (10k cycles) against a 2-deep reference queue: order preserved, no loss, in_ready never 1 in TWO.
